sd_clk_div_gen: RTL and testbench

SD_CLK_DIV_GEN -- requirements
Module: sd_clk_div_gen

---
 rtl/sdhci_clk_pkg.sv | 11 +
 rtl/sd_clk_div_gen.sv | 202 ++++++++++++++++++++
 tb/tb_sd_clk_div_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdhci_clk_pkg.sv
// Shared types for the SD card clock divider/generator.
package sdhci_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SETTLE = 2'd3
    } sd_clk_state_e;

endpackage : sdhci_clk_pkg

// File: rtl/sd_clk_div_gen.sv
// SD card clock generator: programmable half-period divider with glitch-free
// enable/pause gating and Internal Clock Stable reporting after divider loads.
module sd_clk_div_gen
    import sdhci_clk_pkg::*;
#(
    parameter int unsigned DivWidth     = 10,
    parameter int unsigned StableCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sd_clk_en_i,
    input  logic                pause_i,
    input  logic [DivWidth-1:0] div_sel_i,
    output logic                sd_clk_o,
    output logic                sd_clk_rise_o,
    output logic                sd_clk_fall_o,
    output logic                clk_stable_de_o,
    output logic                clk_stable_d_o,
    output logic                clk_active_o
);

    localparam int unsigned SettleW = 8;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(StableCycles - 1);

    sd_clk_state_e         state_q, state_d;
    logic [DivWidth-1:0]   div_q, div_d;
    logic [DivWidth-1:0]   cnt_q, cnt_d;
    logic [SettleW-1:0]    settle_q, settle_d;
    logic                  pend_q, pend_d;
    logic                  active_q, active_d;
    logic                  sd_clk_q, sd_clk_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  stb_de_q, stb_de_d;
    logic                  stb_val_q, stb_val_d;

    logic [DivWidth-1:0]   half_m1;
    logic                  phase_end;
    logic                  mismatch;
    logic                  need_load;
    logic                  load_ok;

    // Divider value 0 behaves as 1; phase_end also serves as the low-time guard in IDLE.
    assign half_m1   = (div_q == '0) ? '0 : div_q - DivWidth'(1);
    assign phase_end = (cnt_q >= half_m1);
    assign mismatch  = (div_sel_i != div_q);
    assign need_load = mismatch || pend_q;
    assign load_ok   = (state_q != ST_RUN) || !sd_clk_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        pend_d    = pend_q;
        sd_clk_d  = sd_clk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        stb_de_d  = 1'b0;
        stb_val_d = 1'b0;

        // A new divider is reported unstable once, when first seen.
        if (mismatch && !pend_q) begin
            stb_de_d = 1'b1;
        end

        if (need_load && load_ok) begin
            state_d  = ST_SETTLE;
            div_d    = div_sel_i;
            cnt_d    = '0;
            pend_d   = 1'b0;
            sd_clk_d = 1'b0;
            // Coming out of RUN the clock has already been low for one cycle.
            settle_d = (state_q == ST_RUN) ? SettleW'(1) : '0;
        end else begin
            if (need_load) begin
                pend_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sd_clk_en_i && !pause_i && phase_end) begin
                        state_d  = ST_RUN;
                        sd_clk_d = 1'b1;
                        rise_d   = 1'b1;
                        cnt_d    = '0;
                    end else if (!phase_end) begin
                        cnt_d = cnt_q + DivWidth'(1);
                    end
                end
                ST_RUN: begin
                    // Gating only ever happens with the clock already low.
                    if (!sd_clk_q && !sd_clk_en_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (!sd_clk_q && pause_i) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (phase_end) begin
                        sd_clk_d = !sd_clk_q;
                        rise_d   = !sd_clk_q;
                        fall_d   = sd_clk_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + DivWidth'(1);
                    end
                end
                ST_HOLD: begin
                    if (!sd_clk_en_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (!pause_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q >= SettleLast) begin
                        stb_de_d  = 1'b1;
                        stb_val_d = 1'b1;
                        cnt_d     = '0;
                        if (sd_clk_en_i && !pause_i) begin
                            state_d  = ST_RUN;
                            sd_clk_d = 1'b1;
                            rise_d   = 1'b1;
                        end else if (!sd_clk_en_i) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        settle_d = settle_q + SettleW'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sd_clk_d = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end

        active_d = (state_d == ST_RUN);
    end

    // State and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            settle_q <= '0;
            pend_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    // Active divider value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // SD clock and edge strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sd_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sd_clk_q <= sd_clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Internal Clock Stable register-write pair.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_de_q  <= 1'b0;
            stb_val_q <= 1'b0;
        end else begin
            stb_de_q  <= stb_de_d;
            stb_val_q <= stb_val_d;
        end
    end

    assign sd_clk_o        = sd_clk_q;
    assign sd_clk_rise_o   = rise_q;
    assign sd_clk_fall_o   = fall_q;
    assign clk_stable_de_o = stb_de_q;
    assign clk_stable_d_o  = stb_val_q;
    assign clk_active_o    = active_q;

endmodule : sd_clk_div_gen

// File: tb/tb_sd_clk_div_gen.sv
// Directed/randomized bench for sd_clk_div_gen; the expected SD clock waveform
// is computed arithmetically from the half-period and the phase since a rise.
module tb_sd_clk_div_gen;

    localparam int unsigned DW = 10;
    localparam int unsigned S  = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          sd_clk_en_i;
    logic          pause_i;
    logic [DW-1:0] div_sel_i;
    logic          sd_clk_o;
    logic          sd_clk_rise_o;
    logic          sd_clk_fall_o;
    logic          clk_stable_de_o;
    logic          clk_stable_d_o;
    logic          clk_active_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_clk = 1'b0;

    sd_clk_div_gen #(
        .DivWidth     (DW),
        .StableCycles (S)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sd_clk_en_i     (sd_clk_en_i),
        .pause_i         (pause_i),
        .div_sel_i       (div_sel_i),
        .sd_clk_o        (sd_clk_o),
        .sd_clk_rise_o   (sd_clk_rise_o),
        .sd_clk_fall_o   (sd_clk_fall_o),
        .clk_stable_de_o (clk_stable_de_o),
        .clk_stable_d_o  (clk_stable_d_o),
        .clk_active_o    (clk_active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference level of an SD clock with half-period h, i cycles after a rise.
    function automatic logic ref_level(input int i, input int h);
        return (i % (2 * h)) < h;
    endfunction

    // Advance one cycle, sample after the edge, check strobe/write-pair relations.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        chk("rise_strobe", 32'(sd_clk_rise_o), 32'(sd_clk_o & ~prev_clk));
        chk("fall_strobe", 32'(sd_clk_fall_o), 32'(~sd_clk_o & prev_clk));
        chk("stable_d_without_de", 32'(clk_stable_d_o & ~clk_stable_de_o), 32'd0);
        prev_clk = sd_clk_o;
    endtask

    task automatic expect_wave(input int h, input int ofs, input int n, input string tag);
        int f0;
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            f0 = fails;
            step();
            chk({tag, "_level"}, 32'(sd_clk_o), 32'(ref_level(i + ofs, h)));
            chk({tag, "_no_write"}, 32'(clk_stable_de_o), 32'd0);
            chk({tag, "_active"}, 32'(clk_active_o), 32'd1);
            if (fails != f0) ok = 1'b0;
        end
    endtask

    task automatic wait_stable(input int budget, output int n_steps, output int n_zero);
        bit found;
        found   = 1'b0;
        n_steps = 0;
        n_zero  = 0;
        while (!found && n_steps < budget) begin
            step();
            n_steps++;
            if (clk_stable_de_o && !clk_stable_d_o) n_zero++;
            if (clk_stable_de_o && clk_stable_d_o) found = 1'b1;
        end
        chk("stable_write_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_rise(input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (sd_clk_rise_o) found = 1'b1;
        end
        chk("rise_seen", 32'(found), 32'd1);
    endtask

    // Starts on a rise sample; pause for l cycles once low, then release.
    task automatic pause_seq(input int h, input int l);
        pause_i = 1'b1;
        for (int j = 1; j <= h + 1; j++) begin
            step();
            chk("pause_high_completes", 32'(sd_clk_o), 32'(j < h));
            chk("pause_active", 32'(clk_active_o), 32'(j <= h));
        end
        for (int j = 0; j < l; j++) begin
            step();
            chk("hold_low", 32'(sd_clk_o), 32'd0);
            chk("hold_inactive", 32'(clk_active_o), 32'd0);
        end
        pause_i = 1'b0;
        for (int j = 0; j < h; j++) begin
            step();
            chk("release_low", 32'(sd_clk_o), 32'd0);
            chk("release_active", 32'(clk_active_o), 32'd1);
        end
        step();
        chk("release_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(h, 1, 4 * h, "after_pause");
    endtask

    // Starts on a rise sample; disable, idle a while, re-enable.
    task automatic disable_seq(input int h);
        sd_clk_en_i = 1'b0;
        for (int j = 1; j <= h + 1; j++) begin
            step();
            chk("dis_high_completes", 32'(sd_clk_o), 32'(j < h));
            chk("dis_active", 32'(clk_active_o), 32'(j <= h));
        end
        for (int j = 0; j < 2 * h + 4; j++) begin
            step();
            chk("idle_low", 32'(sd_clk_o), 32'd0);
            chk("idle_inactive", 32'(clk_active_o), 32'd0);
        end
        sd_clk_en_i = 1'b1;
        step();
        chk("enable_rise_next", 32'(sd_clk_rise_o), 32'd1);
        chk("enable_active", 32'(clk_active_o), 32'd1);
        expect_wave(h, 1, 4 * h, "after_enable");
    endtask

    // Starts on a rise sample; disable and change divider together.
    task automatic simul_seq(input int h, input int hn);
        sd_clk_en_i = 1'b0;
        div_sel_i   = DW'(hn);
        for (int j = 1; j <= h + S; j++) begin
            step();
            chk("sim_clk", 32'(sd_clk_o), 32'(j < h));
            chk("sim_de", 32'(clk_stable_de_o), 32'(j == 1 || j == h + S));
            chk("sim_d", 32'(clk_stable_d_o), 32'(j == h + S));
            chk("sim_active", 32'(clk_active_o), 32'(j <= h));
        end
        for (int j = 0; j < 10; j++) begin
            step();
            chk("sim_idle_low", 32'(sd_clk_o | clk_stable_de_o | clk_active_o), 32'd0);
        end
    endtask

    initial begin
        int n;
        int z;
        int h;
        int hn;

        // Reset and first settle with divider 4.
        rst_ni      = 1'b0;
        sd_clk_en_i = 1'b1;
        pause_i     = 1'b0;
        div_sel_i   = DW'(4);
        repeat (3) @(negedge clk_i);
        chk("rst_clk", 32'(sd_clk_o), 32'd0);
        chk("rst_strobes", 32'(sd_clk_rise_o | sd_clk_fall_o), 32'd0);
        chk("rst_de", 32'(clk_stable_de_o), 32'd0);
        chk("rst_active", 32'(clk_active_o), 32'd0);
        rst_ni   = 1'b1;
        prev_clk = 1'b0;
        for (int k = 0; k <= int'(S); k++) begin
            step();
            chk("boot_clk", 32'(sd_clk_o), 32'(k == int'(S)));
            chk("boot_de", 32'(clk_stable_de_o), 32'(k == 0 || k == int'(S)));
            chk("boot_d", 32'(clk_stable_d_o), 32'(k == int'(S)));
            chk("boot_active", 32'(clk_active_o), 32'(k == int'(S)));
        end
        expect_wave(4, 1, 24, "div4");

        // Divider 4 -> 2 during the high phase.
        step();
        chk("chg_phase1_high", 32'(sd_clk_o), 32'd1);
        div_sel_i = DW'(2);
        for (int p = 2; p <= 8; p++) begin
            step();
            chk("chg_clk", 32'(sd_clk_o), 32'(p < 4 || p == 8));
            chk("chg_de", 32'(clk_stable_de_o), 32'(p == 2 || p == 8));
            chk("chg_d", 32'(clk_stable_d_o), 32'(p == 8));
            chk("chg_active", 32'(clk_active_o), 32'(p <= 4 || p == 8));
        end
        expect_wave(2, 1, 16, "div2");

        // Divider 0 and 1 both give period 2.
        div_sel_i = DW'(0);
        wait_stable(40, n, z);
        chk("div0_zero_writes", 32'(z), 32'd1);
        chk("div0_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(1, 1, 12, "div0");
        div_sel_i = DW'(1);
        wait_stable(40, n, z);
        chk("div1_zero_writes", 32'(z), 32'd1);
        chk("div1_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(1, 1, 12, "div1");

        // Pause with divider 3.
        div_sel_i = DW'(3);
        wait_stable(40, n, z);
        chk("div3_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(3, 1, 12, "div3");
        pause_seq(3, 5);

        // Randomized divider: pause, disable, simultaneous disable + change.
        h = int'($urandom_range(1, 6));
        if (h >= 3) h++;
        div_sel_i = DW'(h);
        wait_stable(40, n, z);
        chk("rnd_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(h, 1, 4 * h, "rnd_div");
        pause_seq(h, int'($urandom_range(1, 12)));
        disable_seq(h);
        hn = (h % 7) + 1;
        simul_seq(h, hn);

        // Two divider changes back to back while settling.
        div_sel_i   = DW'(9);
        sd_clk_en_i = 1'b1;
        step();
        chk("resettle_first_de", 32'(clk_stable_de_o), 32'd1);
        chk("resettle_first_d", 32'(clk_stable_d_o), 32'd0);
        chk("resettle_first_clk", 32'(sd_clk_o | clk_active_o), 32'd0);
        div_sel_i = DW'(2);
        wait_stable(40, n, z);
        chk("resettle_steps", 32'(n), 32'(S + 1));
        chk("resettle_zero_writes", 32'(z), 32'd1);
        chk("resettle_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(2, 1, 20, "resettle_div2");

        // Maximum divider.
        div_sel_i = DW'(1023);
        wait_stable(40, n, z);
        chk("div1023_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(1023, 1, 4200, "div1023");

        // Reset while the clock is high.
        wait_rise(2100);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_clk", 32'(sd_clk_o), 32'd0);
        chk("midrst_strobes", 32'(sd_clk_rise_o | sd_clk_fall_o), 32'd0);
        chk("midrst_active_de", 32'(clk_active_o | clk_stable_de_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni   = 1'b1;
        prev_clk = 1'b0;
        wait_stable(40, n, z);
        chk("postrst_steps", 32'(n), 32'(S + 1));
        chk("postrst_zero_writes", 32'(z), 32'd1);
        chk("postrst_rise", 32'(sd_clk_rise_o), 32'd1);
        expect_wave(1023, 1, 200, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sd_clk_div_gen
